// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control-unit FSM for the multi-cycle CPU.
// Steps every instruction through IF/ID/EXE/MEM/WB and drives the datapath
// selects and enables for the PC, IR, extender, ALU, register file and data memory.
// Ports:
//   CLK, Reset                  clock (rising edge), asynchronous active-low reset
//   op, zero                    IR opcode field, ALU zero flag
//   PCWre, IRWre, InsMemRW      PC write, IR load, instruction-memory read
//   ExtSel, ALUSrcA, ALUSrcB    extender mode, ALU operand selects
//   ALUOp                       ALU function
//   RegDst, RegWre, DBDataSrc   register-file destination, write enable, write-back source
//   mRD, mWR                    data-memory read / write enables
//   PCSrc                       next-PC select
//   state, halted               current state (debug), sticky halt flag
module multicycle_ctrl #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               ExtSel,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegDst,
    output logic               RegWre,
    output logic               mRD,
    output logic               mWR,
    output logic               DBDataSrc,
    output logic [1:0]         PCSrc,
    output logic [2:0]         state,
    output logic               halted
);

    localparam logic [OP_W-1:0] OpAdd  = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OpAddi = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OpOri  = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OpSll  = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OpSlt  = OP_W'(6'b100111);
    localparam logic [OP_W-1:0] OpSw   = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OpLw   = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OpBeq  = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OpJ    = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OpHalt = OP_W'(6'b111111);

    typedef enum logic [2:0] {
        SIf    = 3'b000,
        SId    = 3'b001,
        SExeLs = 3'b010,
        SMem   = 3'b011,
        SWbLd  = 3'b100,
        SExeBr = 3'b101,
        SExeAl = 3'b110,
        SWbAl  = 3'b111
    } state_e;

    state_e state_q, state_d;
    logic   halted_q, halted_d;

    // Opcode decode
    logic               is_alu, is_rtype, is_sll, is_sw, is_lw, is_beq, is_j, is_halt, ext_op;
    logic [ALUOP_W-1:0] alu_op;

    always_comb begin
        is_alu   = 1'b0;
        is_rtype = 1'b0;
        is_sll   = 1'b0;
        is_sw    = 1'b0;
        is_lw    = 1'b0;
        is_beq   = 1'b0;
        is_j     = 1'b0;
        is_halt  = 1'b0;
        ext_op   = 1'b0;
        alu_op   = '0;
        case (op)
            OpAdd:  begin is_alu = 1'b1; is_rtype = 1'b1; end
            OpSub:  begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = ALUOP_W'(1); end
            OpAddi: begin is_alu = 1'b1; ext_op = 1'b1; end
            OpAnd:  begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = ALUOP_W'(4); end
            OpOri:  begin is_alu = 1'b1; alu_op = ALUOP_W'(3); end
            OpSll:  begin is_alu = 1'b1; is_rtype = 1'b1; is_sll = 1'b1; alu_op = ALUOP_W'(2); end
            OpSlt:  begin is_alu = 1'b1; is_rtype = 1'b1; alu_op = ALUOP_W'(5); end
            OpSw:   begin is_sw = 1'b1; ext_op = 1'b1; end
            OpLw:   begin is_lw = 1'b1; ext_op = 1'b1; end
            OpBeq:  begin is_beq = 1'b1; ext_op = 1'b1; alu_op = ALUOP_W'(1); end
            OpJ:    is_j = 1'b1;
            OpHalt: is_halt = 1'b1;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= SIf;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Next state; once halted the FSM parks in SId and ignores op
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        unique case (state_q)
            SIf: state_d = SId;
            SId: begin
                if (halted_q)         state_d = SId;
                else if (is_j)        state_d = SIf;
                else if (is_beq)      state_d = SExeBr;
                else if (is_sw || is_lw) state_d = SExeLs;
                else if (is_halt)     halted_d = 1'b1;
                else if (is_alu)      state_d = SExeAl;
                else                  state_d = SIf;
            end
            SExeAl: state_d = SWbAl;
            SWbAl:  state_d = SIf;
            SExeBr: state_d = SIf;
            SExeLs: state_d = SMem;
            SMem:   state_d = is_lw ? SWbLd : SIf;
            SWbLd:  state_d = SIf;
        endcase
    end

    // Outputs
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = '0;
        RegDst    = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        if (!halted_q) begin
            ExtSel = (state_q != SIf) && ext_op;
            unique case (state_q)
                SIf: begin
                    InsMemRW = 1'b1;
                    IRWre    = 1'b1;
                end
                SId: begin
                    if (is_j) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end else if (!(is_alu || is_sw || is_lw || is_beq || is_halt)) begin
                        // Undefined opcode retires here as a NOP
                        PCWre = 1'b1;
                    end
                end
                SExeAl: begin
                    ALUSrcA = is_sll;
                    ALUSrcB = !is_rtype;
                    ALUOp   = alu_op;
                end
                SExeLs: begin
                    ALUSrcB = 1'b1;
                    ALUOp   = alu_op;
                end
                SExeBr: begin
                    ALUOp = alu_op;
                    PCWre = 1'b1;
                    PCSrc = zero ? 2'b01 : 2'b00;
                end
                SMem: begin
                    mRD   = is_lw;
                    mWR   = is_sw;
                    PCWre = is_sw;
                end
                SWbAl: begin
                    RegWre = 1'b1;
                    RegDst = is_rtype;
                    PCWre  = 1'b1;
                end
                SWbLd: begin
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                end
            endcase
        end
    end

    assign state  = state_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam logic [5:0] ADD  = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
    localparam logic [5:0] AND_ = 6'b010000, ORI = 6'b010010, SLL  = 6'b011000;
    localparam logic [5:0] SLT  = 6'b100111, SW  = 6'b110000, LW   = 6'b110001;
    localparam logic [5:0] BEQ  = 6'b110100, J   = 6'b111000, HALT = 6'b111111;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] op;
    logic       zero;
    logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
    logic [2:0] ALUOp;
    logic       RegDst, RegWre, mRD, mWR, DBDataSrc;
    logic [1:0] PCSrc;
    logic [2:0] state;
    logic       halted;

    always #5 CLK = ~CLK;

    multicycle_ctrl #(.OP_W(6), .ALUOP_W(3)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
        .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
        .PCSrc(PCSrc), .state(state), .halted(halted)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre, irwre, insmem, ext, srca, srcb;
        logic [2:0] aluop;
        logic       regdst, regwre, mrd, mwr, dbsrc;
        logic [1:0] pcsrc;
        logic       halted;
    } ctl_t;

    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];
    logic [5:0] defined_ops [11] = '{ADD, SUB, ADDI, AND_, ORI, SLL, SLT, SW, LW, BEQ, J};

    function automatic ctl_t obs();
        ctl_t c;
        c.st = state; c.pcwre = PCWre; c.irwre = IRWre; c.insmem = InsMemRW; c.ext = ExtSel;
        c.srca = ALUSrcA; c.srcb = ALUSrcB; c.aluop = ALUOp; c.regdst = RegDst;
        c.regwre = RegWre; c.mrd = mRD; c.mwr = mWR; c.dbsrc = DBDataSrc; c.pcsrc = PCSrc;
        c.halted = halted;
        return c;
    endfunction

    function automatic ctl_t if_rec();
        ctl_t c = '0;
        c.irwre  = 1'b1;
        c.insmem = 1'b1;
        return c;
    endfunction

    // Reference: expected per-cycle control words for one instruction, from IF to its last state
    function automatic void build(input logic [5:0] o, input logic z);
        ctl_t c;
        logic ext, alu, rtype;
        logic [2:0] fn;
        ext   = o inside {ADDI, LW, SW, BEQ};
        alu   = o inside {ADD, SUB, ADDI, AND_, ORI, SLL, SLT};
        rtype = o inside {ADD, SUB, AND_, SLL, SLT};
        case (o)
            SUB, BEQ: fn = 3'd1;
            SLL:      fn = 3'd2;
            ORI:      fn = 3'd3;
            AND_:     fn = 3'd4;
            SLT:      fn = 3'd5;
            default:  fn = 3'd0;
        endcase
        exp_q.delete();
        exp_q.push_back(if_rec());
        c = '0; c.st = 3'd1; c.ext = ext;
        if (o == J) begin c.pcwre = 1'b1; c.pcsrc = 2'b10; end
        else if (!(alu || o inside {LW, SW, BEQ, HALT})) c.pcwre = 1'b1;
        exp_q.push_back(c);
        if (alu) begin
            c = '0; c.st = 3'd6; c.ext = ext; c.srca = (o == SLL); c.srcb = !rtype; c.aluop = fn;
            exp_q.push_back(c);
            c = '0; c.st = 3'd7; c.ext = ext; c.regwre = 1'b1; c.regdst = rtype; c.pcwre = 1'b1;
            exp_q.push_back(c);
        end else if (o == BEQ) begin
            c = '0; c.st = 3'd5; c.ext = 1'b1; c.aluop = 3'd1; c.pcwre = 1'b1;
            c.pcsrc = z ? 2'b01 : 2'b00;
            exp_q.push_back(c);
        end else if (o == LW || o == SW) begin
            c = '0; c.st = 3'd2; c.ext = 1'b1; c.srcb = 1'b1;
            exp_q.push_back(c);
            c = '0; c.st = 3'd3; c.ext = 1'b1; c.mrd = (o == LW); c.mwr = (o == SW);
            c.pcwre = (o == SW);
            exp_q.push_back(c);
            if (o == LW) begin
                c = '0; c.st = 3'd4; c.ext = 1'b1; c.regwre = 1'b1; c.dbsrc = 1'b1; c.pcwre = 1'b1;
                exp_q.push_back(c);
            end
        end
    endfunction

    task automatic test_reset();
        Reset = 1'b0; op = ADD; zero = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            checks++;
            if (obs() !== if_rec()) begin
                errors++;
                $display("FAIL reset: got %h expected %h", obs(), if_rec());
            end
        end
        @(posedge CLK); #1 Reset = 1'b1;
    endtask

    task automatic test_alu_ops();
        logic [5:0] seq [7] = '{ADD, SUB, ADDI, AND_, ORI, SLL, SLT};
        foreach (seq[k]) begin
            op = seq[k]; zero = 1'($urandom);
            build(op, zero);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge CLK);
                checks++;
                if (obs() !== exp_q[i]) begin
                    errors++;
                    $display("FAIL alu op=%b step %0d: got %h expected %h", op, i, obs(), exp_q[i]);
                end
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic test_mem_branch();
        logic [5:0] seq [4] = '{LW, SW, BEQ, BEQ};
        logic       zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        foreach (seq[k]) begin
            op = seq[k]; zero = zs[k];
            build(op, zero);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge CLK);
                checks++;
                if (obs() !== exp_q[i]) begin
                    errors++;
                    $display("FAIL mem/branch op=%b z=%b step %0d: got %h expected %h",
                             op, zero, i, obs(), exp_q[i]);
                end
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic test_jump_halt();
        ctl_t h = '0;
        h.st = 3'd1; h.halted = 1'b1;
        op = J; zero = 1'b0;
        build(op, zero);
        build(HALT, 1'b0);
        exp_q.push_front(if_rec());
        // j is two cycles (IF, ID) followed by halt's IF, ID
        begin
            ctl_t jid = '0;
            jid.st = 3'd1; jid.pcwre = 1'b1; jid.pcsrc = 2'b10;
            exp_q.insert(1, jid);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 2) op = HALT;
            @(negedge CLK);
            checks++;
            if (obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL jump/halt step %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
            @(posedge CLK); #1;
        end
        for (int i = 0; i < 10; i++) begin
            op = 6'($urandom); zero = 1'($urandom);
            @(negedge CLK);
            checks++;
            if (obs() !== h) begin
                errors++;
                $display("FAIL halted cycle %0d: got %h expected %h", i, obs(), h);
            end
            @(posedge CLK); #1;
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (obs() !== if_rec()) begin
            errors++;
            $display("FAIL halt reset: got %h expected %h", obs(), if_rec());
        end
        @(posedge CLK); #1 Reset = 1'b1;
    endtask

    task automatic test_reset_mid();
        op = SW; zero = 1'b0;
        build(op, zero);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL sw before reset step %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
            if (i < 3) begin @(posedge CLK); #1; end
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (obs() !== if_rec()) begin
            errors++;
            $display("FAIL reset in MEM: got %h expected %h", obs(), if_rec());
        end
        @(posedge CLK); #1 Reset = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(3) == 0) begin
                op = 6'($urandom);
                if (op == HALT) op = 6'b000011;
            end else begin
                op = defined_ops[$urandom_range(10)];
            end
            zero = 1'($urandom);
            build(op, zero);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge CLK);
                checks++;
                if (obs() !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random op=%b z=%b step %0d: got %h expected %h",
                             op, zero, i, obs(), exp_q[i]);
                end
                @(posedge CLK); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mem_branch();
        test_jump_halt();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
